// File: rtl/jtframe_tilemap_fetch_if.sv
// CPU-side VRAM access port of the tilemap attribute fetcher.
// Handshake: the master raises cpu_cs with cpu_we/cpu_addr/cpu_dout stable and holds them
// until cpu_ok pulses for one clk; cpu_din is valid with cpu_ok and held afterwards.
// A cpu_cs still high in the clk after cpu_ok is taken as a new access.
interface jtframe_tilemap_fetch_if #(
  parameter int AW = 11
);
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_ok;

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_dout,
    input  cpu_din, cpu_ok
  );

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_dout,
    output cpu_din, cpu_ok
  );
endinterface

// File: rtl/jtframe_tilemap_fetch.sv
// Fetches each tile's two-byte map entry one column ahead of the beam, commits it to the
// tilemap at the last pixel of the current tile, and slots CPU VRAM accesses in between.
module jtframe_tilemap_fetch #(
  parameter int MAP_HW = 8,
  parameter int MAP_VW = 8,
  parameter int VA     = MAP_HW + MAP_VW - 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic [MAP_HW-1:0] hdump,
  input  logic [MAP_VW-1:0] vdump,
  input  logic              blankn,
  output logic [VA:0]       ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  jtframe_tilemap_fetch_if.slave cpu,
  output logic [9:0]        code,
  output logic [3:0]        pal,
  output logic              hflip,
  output logic              vflip,
  output logic [2:0]        st_dbg
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] F0   = 3'd1;
  localparam logic [2:0] F1   = 3'd2;
  localparam logic [2:0] F2   = 3'd3;
  localparam logic [2:0] C0   = 3'd4;
  localparam logic [2:0] C1   = 3'd5;

  localparam logic [MAP_HW-4:0] COL_ONE = {{(MAP_HW-4){1'b0}}, 1'b1};

  logic [2:0]        st;
  logic              trig;
  logic              commit;
  logic              pend;
  logic [MAP_HW-4:0] col;
  logic [VA-1:0]     t_now;
  logic [VA-1:0]     tgt;
  logic [VA-1:0]     go_t;
  logic [7:0]        byte0;
  logic [7:0]        din_q;
  logic [9:0]        nx_code;
  logic [3:0]        nx_pal;
  logic              nx_hflip;
  logic              nx_vflip;
  logic              unused_vlow;

  assign trig   = pxl_cen && (hdump[2:0] == 3'd4) && blankn;
  assign commit = pxl_cen && (hdump[2:0] == 3'd7);

  // Next column; the adder is exactly as wide as the column field so the last column wraps to 0
  assign col         = hdump[MAP_HW-1:3] + COL_ONE;
  assign t_now       = {vdump[MAP_VW-1:3], col};
  assign go_t        = trig ? t_now : tgt;
  assign unused_vlow = ^vdump[2:0];

  assign st_dbg      = st;
  assign cpu.cpu_ok  = (st == C1);
  // Read data is forwarded straight from the RAM during C1 so it is valid with cpu_ok
  assign cpu.cpu_din = (st == C1 && !cpu.cpu_we) ? ram_dout : din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      pend     <= 1'b0;
      tgt      <= '0;
      byte0    <= 8'd0;
      din_q    <= 8'd0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= 8'd0;
      nx_code  <= 10'd0;
      nx_pal   <= 4'd0;
      nx_hflip <= 1'b0;
      nx_vflip <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (trig) tgt <= t_now;
      case (st)
        IDLE: begin
          if (trig || pend) begin
            st       <= F0;
            pend     <= 1'b0;
            ram_addr <= {go_t, 1'b0};
          end else if (cpu.cpu_cs && !cpu.cpu_ok) begin
            st       <= C0;
            ram_addr <= cpu.cpu_addr;
            ram_we   <= cpu.cpu_we;
            ram_din  <= cpu.cpu_dout;
          end
        end
        F0: begin
          st       <= F1;
          ram_addr <= {tgt, 1'b1};
        end
        F1: begin
          st    <= F2;
          byte0 <= ram_dout;
        end
        F2: begin
          st       <= IDLE;
          nx_code  <= {ram_dout[5:4], byte0};
          nx_pal   <= ram_dout[3:0];
          nx_hflip <= ram_dout[6];
          nx_vflip <= ram_dout[7];
        end
        C0: begin
          st <= C1;
          if (trig) pend <= 1'b1;
        end
        C1: begin
          st <= IDLE;
          if (!cpu.cpu_we) din_q <= ram_dout;
          if (trig) pend <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // All four fields move together on the commit pixel and hold until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code  <= 10'd0;
      pal   <= 4'd0;
      hflip <= 1'b0;
      vflip <= 1'b0;
    end else if (commit) begin
      code  <= nx_code;
      pal   <= nx_pal;
      hflip <= nx_hflip;
      vflip <= nx_vflip;
    end
  end

endmodule

// File: tb/tb_jtframe_tilemap_fetch.sv
// Directed bench for jtframe_tilemap_fetch: behavioural VRAM, hand-computed map entries,
// expected committed attributes queued as {vflip, hflip, pal, code}.
module tb_jtframe_tilemap_fetch;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pxl_cen = 1'b0;
  logic          blankn = 1'b0;
  logic [7:0]    hdump = 8'd0;
  logic [7:0]    vdump = 8'd0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout = 8'd0;
  logic [9:0]    code;
  logic [3:0]    pal;
  logic          hflip;
  logic          vflip;
  logic [2:0]    st_dbg;

  jtframe_tilemap_fetch_if #(.AW(AW)) cpu ();

  jtframe_tilemap_fetch #(.MAP_HW(8), .MAP_VW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .hdump    (hdump),
    .vdump    (vdump),
    .blankn   (blankn),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .cpu      (cpu.slave),
    .code     (code),
    .pal      (pal),
    .hflip    (hflip),
    .vflip    (vflip),
    .st_dbg   (st_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- VRAM model (1 clk read latency) ----------------
  logic [7:0]    vram [0:2047];
  logic          pk_we = 1'b0;
  logic [AW-1:0] pk_a = '0;
  logic [7:0]    pk_d = 8'd0;

  always @(posedge clk) begin
    if (pk_we) vram[pk_a] <= pk_d;
    else if (ram_we) vram[ram_addr] <= ram_din;
    ram_dout <= vram[ram_addr];
  end

  int f0_cnt = 0;
  int ok_cnt = 0;
  always @(posedge clk) begin
    if (st_dbg == 3'd1) f0_cnt <= f0_cnt + 1;
    if (cpu.cpu_ok) ok_cnt <= ok_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp = 16'd0;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pk_we = 1'b1;
    pk_a  = a;
    pk_d  = d;
    tick();
    pk_we = 1'b0;
  endtask

  task automatic pix;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    hdump   = hdump + 8'd1;
    tick();
  endtask

  task automatic advance_to(input logic [7:0] h);
    int n;
    n = 0;
    while (hdump != h && n < 300) begin
      pix();
      n++;
    end
  endtask

  // Call with hdump[2:0]==4: checks F0 then F1 addresses
  task automatic trig_step(input logic [AW-1:0] a0, input string tag);
    pxl_cen = 1'b1;
    tick();
    check({tag, "_f0"}, {st_dbg, ram_addr}, {3'd1, a0});
    pxl_cen = 1'b0;
    hdump   = hdump + 8'd1;
    tick();
    check({tag, "_f1"}, {st_dbg, ram_addr}, {3'd2, a0[AW-1:1], 1'b1});
  endtask

  // Call with hdump[2:0]==7: outputs must hold before the edge and update after it
  task automatic commit_step(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    check({tag, "_pre"}, {vflip, hflip, pal, code}, cur_exp);
    pxl_cen = 1'b1;
    tick();
    check({tag, "_commit"}, {vflip, hflip, pal, code}, e);
    cur_exp = e;
    pxl_cen = 1'b0;
    hdump   = hdump + 8'd1;
    tick();
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] e, input string tag);
    int lat;
    cpu.cpu_cs   = 1'b1;
    cpu.cpu_we   = 1'b0;
    cpu.cpu_addr = a;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu.cpu_ok && lat < 20);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_data"}, cpu.cpu_din, e);
    cpu.cpu_cs = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int we_bad;
    int base;
    logic [7:0] rnd;

    cpu.cpu_cs   = 1'b0;
    cpu.cpu_we   = 1'b0;
    cpu.cpu_addr = '0;
    cpu.cpu_dout = 8'd0;

    #12;
    check("rst_out", {vflip, hflip, pal, code}, 16'd0);
    check("rst_ram", {st_dbg, ram_we, ram_addr, ram_din}, 32'd0);
    check("rst_cpu", {cpu.cpu_ok, cpu.cpu_din}, 9'd0);
    tick();
    rst_n = 1'b1;
    tick();

    rnd = 8'($urandom_range(0, 255));
    poke(11'd136, 8'h5A);  poke(11'd137, 8'hE9);
    poke(11'd128, 8'h11);  poke(11'd129, 8'h23);
    poke(11'd194, 8'hC3);  poke(11'd195, 8'h4F);
    poke(11'd260, 8'h9E);  poke(11'd261, 8'hB0);
    poke(11'd74,  8'h07);  poke(11'd75,  8'h61);
    poke(11'h020, 8'hA5);  poke(11'h7FF, 8'hC8);
    poke(11'h030, rnd);

    // Basic fetch: row 2, col 3+1 -> t=68
    blankn = 1'b1;
    vdump  = 8'd16;
    hdump  = 8'd24;
    advance_to(8'd28);
    trig_step(11'd136, "basic");
    advance_to(8'd31);
    exp_q.push_back({1'b1, 1'b1, 4'h9, 10'h25A});
    commit_step("basic");

    // Wrap: last column prefetches column 0
    hdump = 8'd248;
    advance_to(8'd252);
    trig_step(11'd128, "wrap");
    advance_to(8'd255);
    exp_q.push_back({1'b0, 1'b0, 4'h3, 10'h211});
    commit_step("wrap");

    // Collision: CPU write raised with the trigger; fetch goes first
    vdump = 8'd24;
    advance_to(8'd4);
    cpu.cpu_cs   = 1'b1;
    cpu.cpu_we   = 1'b1;
    cpu.cpu_addr = 11'h010;
    cpu.cpu_dout = 8'h77;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    check("coll_f0", {st_dbg, ram_addr}, {3'd1, 11'd194});
    lat = 1;
    we_bad = 0;
    while (!cpu.cpu_ok && lat < 20) begin
      if (st_dbg inside {3'd1, 3'd2, 3'd3} && ram_we) we_bad++;
      tick();
      lat++;
      if (st_dbg == 3'd4)
        check("coll_c0", {ram_we, ram_addr, ram_din}, {1'b1, 11'h010, 8'h77});
    end
    check("coll_lat", lat, 6);
    check("coll_we_in_fetch", we_bad, 0);
    cpu.cpu_cs = 1'b0;
    cpu.cpu_we = 1'b0;
    tick();
    check("coll_wr", vram[16], 8'h77);
    hdump = 8'd5;
    advance_to(8'd7);
    exp_q.push_back({1'b0, 1'b1, 4'hF, 10'h0C3});
    commit_step("coll");

    // CPU first: read request one clk before the trigger
    vdump = 8'd32;
    advance_to(8'd11);
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    hdump = 8'd12;
    cpu.cpu_cs   = 1'b1;
    cpu.cpu_we   = 1'b0;
    cpu.cpu_addr = 11'h020;
    tick();
    check("first_c0", st_dbg, 3'd4);
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    check("first_ok", {cpu.cpu_ok, cpu.cpu_din}, {1'b1, 8'hA5});
    cpu.cpu_cs = 1'b0;
    hdump = 8'd13;
    tick();
    check("first_idle", st_dbg, 3'd0);
    tick();
    check("first_f0", {st_dbg, ram_addr}, {3'd1, 11'd260});
    tick();
    check("first_f1", {st_dbg, ram_addr}, {3'd2, 11'd261});
    tick();
    tick();
    advance_to(8'd15);
    exp_q.push_back({1'b1, 1'b0, 4'h0, 10'h39E});
    commit_step("first");
    check("first_din_hold", cpu.cpu_din, 8'hA5);

    // Blanking: a full line without fetches, CPU reads at full speed
    blankn = 1'b0;
    vdump  = 8'd40;
    base   = f0_cnt;
    for (int i = 0; i < 256; i++) begin
      pix();
      if (i == 50)  cpu_read(11'h030, rnd, "blank_rd0");
      if (i == 200) cpu_read(11'h7FF, 8'hC8, "blank_rd1");
    end
    check("blank_no_f0", f0_cnt - base, 0);
    check("blank_hold", {vflip, hflip, pal, code}, cur_exp);

    // Reset asserted during C0
    blankn = 1'b1;
    vdump  = 8'd8;
    cpu.cpu_cs   = 1'b1;
    cpu.cpu_we   = 1'b0;
    cpu.cpu_addr = 11'h030;
    tick();
    check("rst2_c0", st_dbg, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_out", {vflip, hflip, pal, code}, 16'd0);
    check("rst2_ram", {st_dbg, ram_we, ram_addr, ram_din}, 32'd0);
    check("rst2_cpu", {cpu.cpu_ok, cpu.cpu_din}, 9'd0);
    cpu.cpu_cs = 1'b0;
    base = ok_cnt;
    tick();
    rst_n = 1'b1;
    cur_exp = 16'd0;
    blankn  = 1'b0;
    advance_to(8'd23);
    exp_q.push_back(16'd0);
    commit_step("rst2_nx");
    advance_to(8'd32);
    check("rst2_no_ok", ok_cnt - base, 0);
    blankn = 1'b1;
    advance_to(8'd36);
    trig_step(11'd74, "rst2");
    advance_to(8'd39);
    exp_q.push_back({1'b0, 1'b1, 4'h1, 10'h207});
    commit_step("rst2");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
